// File: rtl/sw_debounce_ctrl.sv
// Switch-bus debounce controller: accepts a new switch word only after it has
// been sampled unchanged for STABLE_CYCLES edges, then offers it with valid/ready.
module sw_debounce_ctrl #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 1_000_000,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_sync,
    output logic [WIDTH-1:0] sw_stable,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // The candidate's first sample is taken on entry to SETTLE, so the
    // counter only has to cover the remaining STABLE_CYCLES-1 samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sw_stable_q, sw_stable_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               upd_valid_q, upd_valid_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sw_stable_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            upd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_stable_q <= sw_stable_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            upd_valid_q <= upd_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sw_stable_d = sw_stable_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        upd_valid_d = upd_valid_q;

        unique case (state_q)
            IDLE: begin
                if (sw_sync != sw_stable_q) begin
                    cand_d  = sw_sync;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // A return to the published value cancels the update outright.
                if (sw_sync == sw_stable_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sw_sync != cand_q) begin
                    cand_d = sw_sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    sw_stable_d = cand_q;
                    upd_valid_d = 1'b1;
                    state_d     = UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE: begin
                if (upd_ready) begin
                    upd_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                upd_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign sw_stable = sw_stable_q;
    assign upd_valid = upd_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Self-checking bench for sw_debounce_ctrl: directed scenarios plus random
// switch activity, all compared against a run-length reference model.
module tb_sw_debounce_ctrl;

    localparam int WIDTH  = 10;
    localparam int STABLE = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] sw_stable;
    logic             upd_valid;
    logic             upd_ready;
    logic             busy;

    int nCompared;
    int nMismatched;

    // Reference model: counts consecutive identical samples of a word that
    // differs from the published one; publishes when the run reaches STABLE.
    logic [WIDTH-1:0] mStable;
    logic [WIDTH-1:0] mCand;
    bit               mValid;
    bit               mTracking;
    int               mRun;

    sw_debounce_ctrl #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_sync(sw_sync),
        .sw_stable(sw_stable),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void modelReset();
        mStable   = '0;
        mCand     = '0;
        mValid    = 1'b0;
        mTracking = 1'b0;
        mRun      = 0;
    endfunction

    function automatic void modelEdge(input logic [WIDTH-1:0] s, input logic r);
        if (mValid) begin
            if (r) mValid = 1'b0;
        end else if (!mTracking) begin
            if (s != mStable) begin
                mTracking = 1'b1;
                mCand     = s;
                mRun      = 1;
            end
        end else if (s == mStable) begin
            mTracking = 1'b0;
        end else if (s != mCand) begin
            mCand = s;
            mRun  = 1;
        end else begin
            mRun++;
            if (mRun == STABLE) begin
                mStable   = mCand;
                mValid    = 1'b1;
                mTracking = 1'b0;
            end
        end
    endfunction

    // Entered and left 4 ns after a rising edge: drive, take one edge,
    // advance the model, then settle 4 ns before the caller samples.
    task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic r);
        sw_sync   = s;
        upd_ready = r;
        @(posedge clk);
        modelEdge(s, r);
        #4;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        sw_sync   = 10'h2C3;
        upd_ready = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #4;
        nCompared++;
        if ({sw_stable, upd_valid, busy} !== {10'h000, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_hold: got stable=%h valid=%b busy=%b, expected 000/0/0",
                     sw_stable, upd_valid, busy);
        end
        sw_sync = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'h000, 1'b1);
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                nMismatched++;
                $display("[TB] FAIL reset_idle: got %h/%b/%b expected %h/%b/%b",
                         sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
            end
        end
    endtask

    task automatic test_clean_change();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(10'h0A5, 1'b1);
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                nMismatched++;
                $display("[TB] FAIL clean_model: cycle %0d got %h/%b/%b expected %h/%b/%b",
                         i, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
            end
            if (i == 0) begin
                nCompared++;
                if (busy !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL clean_busy_E0: got %b expected 1", busy);
                end
            end
            if (i == STABLE - 1) begin
                nCompared++;
                if ({sw_stable, upd_valid} !== {10'h0A5, 1'b1}) begin
                    nMismatched++;
                    $display("[TB] FAIL clean_publish: got %h/%b expected 0a5/1", sw_stable, upd_valid);
                end
            end
            if (i == STABLE) begin
                nCompared++;
                if ({upd_valid, busy} !== 2'b00) begin
                    nMismatched++;
                    $display("[TB] FAIL clean_release: got valid=%b busy=%b expected 0/0", upd_valid, busy);
                end
            end
        end
    endtask

    task automatic test_bounce();
        bit sawValid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus((i < 2) ? 10'h05A : 10'h0A5, 1'b1);
            if (upd_valid) sawValid = 1'b1;
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                nMismatched++;
                $display("[TB] FAIL bounce_model: cycle %0d got %h/%b/%b expected %h/%b/%b",
                         i, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
            end
        end
        nCompared++;
        if ({sawValid, sw_stable, busy} !== {1'b0, 10'h0A5, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL bounce_end: got sawValid=%b stable=%h busy=%b expected 0/0a5/0",
                     sawValid, sw_stable, busy);
        end
    endtask

    task automatic test_restart();
        int firstValid = -1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus((i < 2) ? 10'h05A : 10'h0FF, 1'b1);
            if (upd_valid && firstValid < 0) firstValid = i;
            nCompared++;
            if (sw_stable === 10'h05A) begin
                nMismatched++;
                $display("[TB] FAIL restart_leak: got stable=%h expected never 05a", sw_stable);
            end
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                nMismatched++;
                $display("[TB] FAIL restart_model: cycle %0d got %h/%b/%b expected %h/%b/%b",
                         i, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
            end
        end
        nCompared++;
        if (firstValid != 2 + STABLE - 1 || sw_stable !== 10'h0FF) begin
            nMismatched++;
            $display("[TB] FAIL restart_timing: got valid at cycle %0d stable=%h expected cycle %0d 0ff",
                     firstValid, sw_stable, 2 + STABLE - 1);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] s;
        logic             r;
        for (int i = 0; i < 16; i++) begin
            s = (i < STABLE) ? 10'h3FF : 10'h000;
            r = (i == STABLE + 3) || (i > STABLE + 4);
            applyStimulus(s, r);
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                nMismatched++;
                $display("[TB] FAIL backpressure_model: cycle %0d got %h/%b/%b expected %h/%b/%b",
                         i, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
            end
            if (i >= STABLE - 1 && i < STABLE + 3) begin
                nCompared++;
                if ({sw_stable, upd_valid} !== {10'h3FF, 1'b1}) begin
                    nMismatched++;
                    $display("[TB] FAIL backpressure_hold: cycle %0d got %h/%b expected 3ff/1",
                             i, sw_stable, upd_valid);
                end
            end
            if (i == STABLE + 3 || i == STABLE + 4) begin
                nCompared++;
                if (busy !== (i == STABLE + 4)) begin
                    nMismatched++;
                    $display("[TB] FAIL backpressure_idle_then_settle: cycle %0d got busy=%b expected %b",
                             i, busy, (i == STABLE + 4));
                end
            end
        end
        nCompared++;
        if (sw_stable !== 10'h000) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_followup: got stable=%h expected 000", sw_stable);
        end
    endtask

    task automatic test_reset_mid();
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < ((phase == 0) ? 2 : STABLE); i++)
                applyStimulus(10'h155, 1'b0);
            nCompared++;
            if (busy !== 1'b1 || upd_valid !== (phase == 1)) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_setup: phase %0d got busy=%b valid=%b", phase, busy, upd_valid);
            end
            reset_n = 1'b0;
            #1;
            modelReset();
            nCompared++;
            if ({sw_stable, upd_valid, busy} !== {10'h000, 1'b0, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_async: phase %0d got %h/%b/%b expected 000/0/0",
                         phase, sw_stable, upd_valid, busy);
            end
            #3;
            reset_n = 1'b1;
            for (int i = 0; i < STABLE + 1; i++) begin
                applyStimulus(10'h155, 1'b1);
                nCompared++;
                if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                    nMismatched++;
                    $display("[TB] FAIL reset_mid_resettle: phase %0d cycle %0d got %h/%b/%b expected %h/%b/%b",
                             phase, i, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
                end
            end
            nCompared++;
            if (sw_stable !== 10'h155) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_final: phase %0d got %h expected 155", phase, sw_stable);
            end
            applyStimulus(10'h000, 1'b1);
            for (int i = 0; i < STABLE + 1; i++) applyStimulus(10'h000, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s;
        int               hold;
        int               cycles = 0;
        while (cycles < 400) begin
            case ($urandom_range(0, 4))
                0: s = 10'h000;
                1: s = 10'h0A5;
                2: s = 10'h05A;
                3: s = 10'h3FF;
                default: s = WIDTH'($urandom);
            endcase
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                applyStimulus(s, ($urandom_range(0, 3) != 0));
                cycles++;
                nCompared++;
                if ({sw_stable, upd_valid, busy} !== {mStable, mValid, mTracking | mValid}) begin
                    nMismatched++;
                    $display("[TB] FAIL random_model: cycle %0d got %h/%b/%b expected %h/%b/%b",
                             cycles, sw_stable, upd_valid, busy, mStable, mValid, mTracking | mValid);
                end
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_clean_change();
        test_bounce();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
